// File: rtl/mem_access_unit.sv
// Memory-stage load/store sequencer: word-aligned byte-enabled bus requests, pipeline stall, load extension.
// Optional MISALIGN_TRAP_EN: misaligned H/W accesses complete immediately with misalign_o instead of touching the bus.
//
// state    | meaning
// ---------+-------------------------------------------------------------
// S_IDLE   | waiting for MemRead_i/MemWrite_i; latches the request
// S_ACCESS | strobes driven from latched request, waiting for mem_ready_i or timeout
// S_DONE   | one-cycle done_o pulse, stall released, strobes low
module mem_access_unit #(
   parameter logic [15:0] TIMEOUT_CYCLES = 16'd255
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        MemRead_i,
   input  logic        MemWrite_i,
   input  logic [2:0]  funct3_i,
   input  logic [31:0] addr_i,
   input  logic [31:0] wdata_i,
   output logic [31:0] mem_addr_o,
   output logic [31:0] mem_wdata_o,
   output logic [3:0]  mem_be_o,
   output logic        mem_re_o,
   output logic        mem_we_o,
   input  logic [31:0] mem_rdata_i,
   input  logic        mem_ready_i,
   output logic [31:0] data_o,
   output logic        stall_o,
   output logic        done_o,
   output logic        bus_err_o,
   output logic        misalign_o
);

   typedef enum logic [1:0] {S_IDLE, S_ACCESS, S_DONE} state_t;

   localparam logic [1:0] SZ_B = 2'd0;
   localparam logic [1:0] SZ_H = 2'd1;
   localparam logic [1:0] SZ_W = 2'd2;

   // Unsigned load encodings have no store counterpart, so they fall back to word on stores.
   function automatic logic [1:0] size_of(input logic is_store, input logic [2:0] f3);
      if (f3 == 3'b000 || (!is_store && f3 == 3'b100))
         return SZ_B;
      else if (f3 == 3'b001 || (!is_store && f3 == 3'b101))
         return SZ_H;
      else
         return SZ_W;
   endfunction

   state_t      state_q, state_d;
   logic [31:0] addr_q, wdata_q, data_q;
   logic [2:0]  f3_q;
   logic        store_q;
   logic [15:0] tmo_cnt_q;
   logic        bus_err_q, misalign_q;
   logic        req, tmo_hit, misalign_req;
   logic [1:0]  acc_size;
   logic [7:0]  lane_byte;
   logic [15:0] lane_half;
   logic [31:0] load_ext, wdata_rep;
   logic [3:0]  be_store;

   assign req      = MemRead_i | MemWrite_i;
   assign acc_size = size_of(store_q, f3_q);
   assign tmo_hit  = (TIMEOUT_CYCLES != 16'd0) && (tmo_cnt_q == 16'd1);

`ifdef MISALIGN_TRAP_EN
   logic [1:0] req_size;
   assign req_size     = size_of(MemWrite_i, funct3_i);
   assign misalign_req = (req_size == SZ_H && addr_i[0]) ||
                         (req_size == SZ_W && addr_i[1:0] != 2'b00);
`else
   assign misalign_req = 1'b0;
`endif

   always_comb begin
      state_d = state_q;
      case (state_q)
         S_IDLE:   if (req) state_d = misalign_req ? S_DONE : S_ACCESS;
         S_ACCESS: if (mem_ready_i || tmo_hit) state_d = S_DONE;
         S_DONE:   state_d = S_IDLE;
         default:  state_d = S_IDLE;
      endcase
   end

   // Lane selection ignores address bits below the access size.
   always_comb begin
      case (addr_q[1:0])
         2'd1:    lane_byte = mem_rdata_i[15:8];
         2'd2:    lane_byte = mem_rdata_i[23:16];
         2'd3:    lane_byte = mem_rdata_i[31:24];
         default: lane_byte = mem_rdata_i[7:0];
      endcase
      lane_half = addr_q[1] ? mem_rdata_i[31:16] : mem_rdata_i[15:0];
      case (acc_size)
         SZ_B: begin
            load_ext  = {{24{lane_byte[7] & ~f3_q[2]}}, lane_byte};
            be_store  = 4'b0001 << addr_q[1:0];
            wdata_rep = {4{wdata_q[7:0]}};
         end
         SZ_H: begin
            load_ext  = {{16{lane_half[15] & ~f3_q[2]}}, lane_half};
            be_store  = addr_q[1] ? 4'b1100 : 4'b0011;
            wdata_rep = {2{wdata_q[15:0]}};
         end
         default: begin
            load_ext  = mem_rdata_i;
            be_store  = 4'b1111;
            wdata_rep = wdata_q;
         end
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q    <= S_IDLE;
         addr_q     <= '0;
         wdata_q    <= '0;
         f3_q       <= '0;
         store_q    <= 1'b0;
         data_q     <= '0;
         tmo_cnt_q  <= '0;
         bus_err_q  <= 1'b0;
         misalign_q <= 1'b0;
      end else begin
         state_q <= state_d;
         case (state_q)
            S_IDLE: begin
               bus_err_q  <= 1'b0;
               misalign_q <= 1'b0;
               if (req) begin
                  addr_q     <= addr_i;
                  wdata_q    <= wdata_i;
                  f3_q       <= funct3_i;
                  store_q    <= MemWrite_i;
                  tmo_cnt_q  <= TIMEOUT_CYCLES;
                  misalign_q <= misalign_req;
               end
            end
            S_ACCESS: begin
               if (mem_ready_i) begin
                  if (!store_q) data_q <= load_ext;
               end else if (tmo_hit) begin
                  bus_err_q <= 1'b1;
                  if (!store_q) data_q <= '0;
               end else if (tmo_cnt_q != 16'd0) begin
                  tmo_cnt_q <= tmo_cnt_q - 16'd1;
               end
            end
            default: begin
               tmo_cnt_q  <= '0;
               bus_err_q  <= 1'b0;
               misalign_q <= 1'b0;
            end
         endcase
      end
   end

   assign mem_addr_o  = {addr_q[31:2], 2'b00};
   assign mem_wdata_o = wdata_rep;
   assign mem_re_o    = (state_q == S_ACCESS) && !store_q;
   assign mem_we_o    = (state_q == S_ACCESS) && store_q;
   assign mem_be_o    = (state_q != S_ACCESS) ? 4'b0000 : (store_q ? be_store : 4'b1111);
   assign stall_o     = ((state_q == S_IDLE) && req) || (state_q == S_ACCESS);
   assign done_o      = (state_q == S_DONE);
   assign data_o      = data_q;
   assign bus_err_o   = bus_err_q;
   assign misalign_o  = misalign_q;

endmodule

// File: tb/tb_mem_access_unit.sv
// Self-checking bench for mem_access_unit: directed vector table, hand-written reset/misalign cases,
// and randomized transactions checked against an arithmetic reference model.
module tb_mem_access_unit;
   localparam int TMO = 4;

   typedef struct {
      logic        st;
      logic [2:0]  f3;
      logic [31:0] addr;
      logic [31:0] wdata;
      logic [31:0] rdata;
      int          waits;
      logic [31:0] exp_data;
      logic [3:0]  exp_be;
      logic [31:0] exp_wdata;
      logic        exp_err;
      logic        exp_mis;
   } vec_t;

   logic        clk = 1'b0;
   logic        rst;
   logic        mem_read, mem_write, mem_ready;
   logic [2:0]  funct3;
   logic [31:0] addr, wdata, mem_rdata;
   logic [31:0] mem_addr, mem_wdata, data;
   logic [3:0]  mem_be;
   logic        mem_re, mem_we, stall, done, bus_err, misalign;

   int          n_cmp = 0;
   int          n_bad = 0;
   int          cur_tag = 0;
   logic [31:0] data_ref = '0;
   vec_t        tbl[14];

   always #5 clk = ~clk;

   mem_access_unit #(.TIMEOUT_CYCLES(16'd4)) dut (
      .clk(clk), .rst(rst),
      .MemRead_i(mem_read), .MemWrite_i(mem_write),
      .funct3_i(funct3), .addr_i(addr), .wdata_i(wdata),
      .mem_addr_o(mem_addr), .mem_wdata_o(mem_wdata), .mem_be_o(mem_be),
      .mem_re_o(mem_re), .mem_we_o(mem_we),
      .mem_rdata_i(mem_rdata), .mem_ready_i(mem_ready),
      .data_o(data), .stall_o(stall), .done_o(done),
      .bus_err_o(bus_err), .misalign_o(misalign)
   );

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_bad++;
         $display("FAIL %s txn=%0d actual=%h required=%h", name, cur_tag, act, exp);
      end
   endtask

   function automatic vec_t mk(input logic st, input logic [2:0] f3, input logic [31:0] a,
                               input logic [31:0] wd, input logic [31:0] rd, input int w,
                               input logic [31:0] ed, input logic [3:0] eb, input logic [31:0] ew,
                               input logic ee, input logic em);
      vec_t v;
      v.st = st; v.f3 = f3; v.addr = a; v.wdata = wd; v.rdata = rd; v.waits = w;
      v.exp_data = ed; v.exp_be = eb; v.exp_wdata = ew; v.exp_err = ee; v.exp_mis = em;
      return v;
   endfunction

   // Reference model: access width in bytes, offset rounded down to that width, then shift/mask.
   function automatic vec_t model(input logic st, input logic [2:0] f3, input logic [31:0] a,
                                  input logic [31:0] wd, input logic [31:0] rd, input int w);
      vec_t        m;
      int          nb, off;
      logic [31:0] mask, v;
      nb = (f3 == 3'd0 || (!st && f3 == 3'd4)) ? 1 :
           (f3 == 3'd1 || (!st && f3 == 3'd5)) ? 2 : 4;
      off = (int'(a[1:0]) / nb) * nb;
      m.st = st; m.f3 = f3; m.addr = a; m.wdata = wd; m.rdata = rd; m.waits = w;
      m.exp_mis = 1'b0;
`ifdef MISALIGN_TRAP_EN
      m.exp_mis = (int'(a[1:0]) % nb) != 0;
`endif
      m.exp_be = 4'(((1 << nb) - 1) << off);
      for (int i = 0; i < 4; i++) m.exp_wdata[8*i +: 8] = wd[8*(i % nb) +: 8];
      mask = (nb == 4) ? 32'hFFFF_FFFF : ((32'd1 << (8*nb)) - 32'd1);
      v = (rd >> (8*off)) & mask;
      if (nb < 4 && !f3[2] && v[8*nb-1]) v = v | ~mask;
      m.exp_data = v;
      m.exp_err = !m.exp_mis && (w + 1 > TMO);
      return m;
   endfunction

   // Entered and left at posedge+1 of an IDLE cycle.
   task automatic run_txn(input vec_t v, input bit drop_req);
      int n_acc;
      n_acc = v.exp_mis ? 0 : (v.exp_err ? TMO : v.waits + 1);
      mem_write = v.st;
      mem_read  = v.st ? 1'($urandom_range(0, 1)) : 1'b1;
      funct3 = v.f3; addr = v.addr; wdata = v.wdata;
      mem_ready = 1'($urandom_range(0, 1));
      mem_rdata = $urandom;
      #1;
      chk("idle_stall", 32'(stall), 32'd1);
      chk("idle_strobes", 32'({mem_re, mem_we}), 32'd0);
      @(posedge clk); #1;
      for (int c = 1; c <= n_acc; c++) begin
         if (drop_req && c > 1) begin
            mem_read = 1'b0; mem_write = 1'b0;
            addr = $urandom; wdata = $urandom; funct3 = 3'($urandom);
         end
         mem_ready = (c == v.waits + 1);
         mem_rdata = mem_ready ? v.rdata : $urandom;
         #1;
         chk("acc_re", 32'(mem_re), 32'(!v.st));
         chk("acc_we", 32'(mem_we), 32'(v.st));
         chk("acc_be", 32'(mem_be), 32'(v.st ? v.exp_be : 4'hF));
         chk("acc_addr", mem_addr, {v.addr[31:2], 2'b00});
         if (v.st) chk("acc_wdata", mem_wdata, v.exp_wdata);
         chk("acc_stall", 32'(stall), 32'd1);
         chk("acc_done", 32'(done), 32'd0);
         @(posedge clk); #1;
      end
      mem_read = 1'b0; mem_write = 1'b0;
      mem_ready = 1'($urandom_range(0, 1));
      mem_rdata = $urandom;
      if (!v.st && !v.exp_mis) data_ref = v.exp_err ? 32'd0 : v.exp_data;
      #1;
      chk("done_pulse", 32'(done), 32'd1);
      chk("done_err", 32'(bus_err), 32'(v.exp_err));
      chk("done_mis", 32'(misalign), 32'(v.exp_mis));
      chk("done_data", data, data_ref);
      chk("done_stall", 32'(stall), 32'd0);
      chk("done_strobes", 32'({mem_re, mem_we, mem_be}), 32'd0);
      @(posedge clk); #1;
      chk("post_done", 32'(done), 32'd0);
      chk("post_flags", 32'({bus_err, misalign}), 32'd0);
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog txn=%0d actual=running required=finished", cur_tag);
      $fatal(1, "watchdog expired");
   end

   initial begin
      vec_t v;
      logic st;
      logic [2:0] f3;
      logic [31:0] a, wd, rd;
      int w;

      rst = 1'b1; mem_read = 1'b0; mem_write = 1'b0; mem_ready = 1'b0;
      funct3 = '0; addr = '0; wdata = '0; mem_rdata = '0;

      tbl[0]  = mk(0, 3'b000, 32'h0103, 0, 32'h80FF_1234, 0, 32'hFFFF_FF80, 4'hF, 0, 0, 0);
      tbl[1]  = mk(0, 3'b101, 32'h0102, 0, 32'h8001_0000, 3, 32'h0000_8001, 4'hF, 0, 0, 0);
      tbl[2]  = mk(1, 3'b000, 32'h0201, 32'h0000_00AB, 0, 2, 0, 4'b0010, 32'hABAB_ABAB, 0, 0);
      tbl[3]  = mk(0, 3'b010, 32'h0400, 0, 32'hDEAD_BEEF, 0, 32'hDEAD_BEEF, 4'hF, 0, 0, 0);
      tbl[4]  = mk(0, 3'b001, 32'h0402, 0, 32'h8001_7FFF, 1, 32'hFFFF_8001, 4'hF, 0, 0, 0);
      tbl[5]  = mk(0, 3'b100, 32'h0401, 0, 32'h1234_56F0, 0, 32'h0000_0056, 4'hF, 0, 0, 0);
      tbl[6]  = mk(1, 3'b001, 32'h0502, 32'h1234_ABCD, 0, 0, 0, 4'b1100, 32'hABCD_ABCD, 0, 0);
      tbl[7]  = mk(1, 3'b010, 32'h0600, 32'hCAFE_F00D, 0, 3, 0, 4'hF, 32'hCAFE_F00D, 0, 0);
      tbl[8]  = mk(0, 3'b010, 32'h0604, 0, 32'h1111_1111, 9, 32'h0, 4'hF, 0, 1, 0);
      tbl[9]  = mk(1, 3'b010, 32'h0608, 32'h0102_0304, 0, 9, 0, 4'hF, 32'h0102_0304, 1, 0);
      tbl[10] = mk(0, 3'b000, 32'h0100, 0, 32'h0000_007F, 0, 32'h0000_007F, 4'hF, 0, 0, 0);
      tbl[11] = mk(0, 3'b011, 32'h0700, 0, 32'h1122_3344, 2, 32'h1122_3344, 4'hF, 0, 0, 0);
      tbl[12] = mk(1, 3'b100, 32'h0800, 32'h5566_7788, 0, 0, 0, 4'hF, 32'h5566_7788, 0, 0);
      tbl[13] = mk(0, 3'b001, 32'h0400, 0, 32'h0000_8000, 0, 32'hFFFF_8000, 4'hF, 0, 0, 0);

      repeat (3) @(posedge clk);
      #1;
      chk("rst_data", data, 32'd0);
      chk("rst_strobes", 32'({mem_re, mem_we, mem_be}), 32'd0);
      chk("rst_flags", 32'({done, bus_err, misalign, stall}), 32'd0);
      rst = 1'b0;
      @(posedge clk); #1;

      for (int i = 0; i < 14; i++) begin
         cur_tag = i;
         run_txn(tbl[i], i == 7);
      end

      // Reset during the second ACCESS cycle of a load.
      cur_tag = 100;
      mem_read = 1'b1; funct3 = 3'b010; addr = 32'h0900; mem_ready = 1'b0;
      @(posedge clk); #1;
      @(posedge clk); #1;
      chk("rst_mid_re_before", 32'(mem_re), 32'd1);
      rst = 1'b1; mem_read = 1'b0;
      @(posedge clk); #1;
      rst = 1'b0;
      data_ref = 32'd0;
      #1;
      chk("rst_mid_strobes", 32'({mem_re, mem_we, mem_be}), 32'd0);
      chk("rst_mid_data", data, 32'd0);
      chk("rst_mid_done", 32'(done), 32'd0);
      chk("rst_mid_stall", 32'(stall), 32'd0);
      @(posedge clk); #1;
      chk("rst_mid_no_done", 32'(done), 32'd0);

      // Misaligned word store.
      cur_tag = 101;
`ifdef MISALIGN_TRAP_EN
      v = mk(1, 3'b010, 32'h0302, 32'h1234_5678, 0, 0, 0, 4'hF, 32'h1234_5678, 0, 1);
`else
      v = mk(1, 3'b010, 32'h0302, 32'h1234_5678, 0, 0, 0, 4'hF, 32'h1234_5678, 0, 0);
`endif
      run_txn(v, 0);

      for (int i = 0; i < 150; i++) begin
         cur_tag = 200 + i;
         st = 1'($urandom_range(0, 1));
         f3 = 3'($urandom);
         a  = $urandom; wd = $urandom; rd = $urandom;
         w  = $urandom_range(0, 5);
         run_txn(model(st, f3, a, wd, rd, w), 1'($urandom_range(0, 1)));
      end

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end
endmodule
